// File: rtl/instr_fetch_issue.sv
// Instruction front end: walks byte-wide program memory, gathers 0/1/2 operands per opcode
// and presents {opcode, operand_a, operand_b} to the execute stage over valid/ready.
module instr_fetch_issue #(
  parameter int unsigned AW         = 8,
  parameter int unsigned START_ADDR = 0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  output logic          mem_ren_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic [7:0]    mem_rdata_i,
  output logic          issue_valid_o,
  input  logic          issue_ready_i,
  output logic [7:0]    instr_o,
  output logic [7:0]    operand_a_o,
  output logic [7:0]    operand_b_o,
  output logic          busy_o,
  output logic          halted_o,
  output logic [AW-1:0] pc_o,
  output logic [15:0]   issue_count_o
);

  localparam logic [AW-1:0] StartPc = AW'(START_ADDR);
  localparam logic [7:0]    OpHalt  = 8'h13;

  typedef enum logic [3:0] {
    StIdle, StFOpc, StDOpc, StFA, StCA, StFB, StCB, StIssue, StHalted
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q;
  logic          mem_end_q;
  logic [7:0]    instr_q, operand_a_q, operand_b_q;
  logic [15:0]   issue_count_q;
  logic          mem_ren_q, issue_valid_q, busy_q, halted_q;
  logic          fetch;

  function automatic logic [1:0] opnd_cnt(input logic [7:0] op);
    if (op <= 8'h0B)      return 2'd2;
    else if (op <= 8'h14) return 2'd1;
    else                  return 2'd0;
  endfunction

  assign fetch = (state_q == StFOpc) || (state_q == StFA) || (state_q == StFB);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_i) state_d = StFOpc;
      StFOpc:   state_d = StDOpc;
      StDOpc:   state_d = (opnd_cnt(mem_rdata_i) == 2'd0) ? StIssue : StFA;
      StFA:     state_d = StCA;
      StCA:     state_d = (opnd_cnt(instr_q) == 2'd2) ? StFB : StIssue;
      StFB:     state_d = StCB;
      StCB:     state_d = StIssue;
      // Once the last address has been read, no further opcode is fetched.
      StIssue: begin
        if (issue_ready_i) state_d = (instr_q == OpHalt || mem_end_q) ? StHalted : StFOpc;
      end
      StHalted: state_d = StHalted;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      pc_q          <= StartPc;
      mem_end_q     <= 1'b0;
      instr_q       <= 8'h00;
      operand_a_q   <= 8'h00;
      operand_b_q   <= 8'h00;
      issue_count_q <= 16'h0000;
      mem_ren_q     <= 1'b0;
      issue_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      // Status outputs are registered from the next state so they line up with state_q.
      mem_ren_q     <= (state_d == StFOpc) || (state_d == StFA) || (state_d == StFB);
      issue_valid_q <= (state_d == StIssue);
      busy_q        <= (state_d != StIdle) && (state_d != StHalted);
      halted_q      <= (state_d == StHalted);
      if (fetch) begin
        pc_q <= pc_q + AW'(1);
        if (&pc_q) mem_end_q <= 1'b1;
      end
      case (state_q)
        StDOpc: begin
          instr_q     <= mem_rdata_i;
          operand_a_q <= 8'h00;
          operand_b_q <= 8'h00;
        end
        StCA:    operand_a_q <= mem_rdata_i;
        StCB:    operand_b_q <= mem_rdata_i;
        StIssue: begin
          if (issue_ready_i && issue_count_q != 16'hFFFF) issue_count_q <= issue_count_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign mem_ren_o     = mem_ren_q;
  assign mem_addr_o    = pc_q;
  assign pc_o          = pc_q;
  assign issue_valid_o = issue_valid_q;
  assign instr_o       = instr_q;
  assign operand_a_o   = operand_a_q;
  assign operand_b_o   = operand_b_q;
  assign busy_o        = busy_q;
  assign halted_o      = halted_q;
  assign issue_count_o = issue_count_q;

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Directed bench for instr_fetch_issue: one default instance plus one starting at address 254.
module tb_instr_fetch_issue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, ready, start_w, ready_w;
  logic        mem_ren, issue_valid, busy, halted;
  logic        mem_ren_w, issue_valid_w, busy_w, halted_w;
  logic [7:0]  mem_addr, pc, instr, opa, opb, rdata;
  logic [7:0]  mem_addr_w, pc_w, instr_w, opa_w, opb_w, rdata_w;
  logic [15:0] cnt, cnt_w;
  logic [7:0]  mem   [256];
  logic [7:0]  mem_w [256];

  int n_cmp = 0;
  int n_bad = 0;
  int n;
  int ren;

  instr_fetch_issue #(.AW(8), .START_ADDR(0)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mem_ren_o(mem_ren), .mem_addr_o(mem_addr),
    .mem_rdata_i(rdata), .issue_valid_o(issue_valid), .issue_ready_i(ready), .instr_o(instr),
    .operand_a_o(opa), .operand_b_o(opb), .busy_o(busy), .halted_o(halted), .pc_o(pc),
    .issue_count_o(cnt)
  );

  instr_fetch_issue #(.AW(8), .START_ADDR(254)) u_dut_w (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_w), .mem_ren_o(mem_ren_w),
    .mem_addr_o(mem_addr_w), .mem_rdata_i(rdata_w), .issue_valid_o(issue_valid_w),
    .issue_ready_i(ready_w), .instr_o(instr_w), .operand_a_o(opa_w), .operand_b_o(opb_w),
    .busy_o(busy_w), .halted_o(halted_w), .pc_o(pc_w), .issue_count_o(cnt_w)
  );

  always @(posedge clk) if (mem_ren) rdata <= mem[mem_addr];
  always @(posedge clk) if (mem_ren_w) rdata_w <= mem_w[mem_addr_w];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n counts cycles from the start/handshake edge; a 40 result means the bound expired.
  task automatic wait_valid(input int n0, output int nc);
    nc = n0;
    while (!issue_valid && nc < 40) begin
      tick();
      nc++;
    end
  endtask

  task automatic wait_valid_w(output int nc);
    nc = 1;
    while (!issue_valid_w && nc < 40) begin
      tick();
      nc++;
    end
  endtask

  task automatic load(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                      input logic [7:0] b3, input logic [7:0] b4);
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = b0; mem[1] = b1; mem[2] = b2; mem[3] = b3; mem[4] = b4;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ready = 1'b1; start_w = 1'b0; ready_w = 1'b1;
    for (int i = 0; i < 256; i++) mem_w[i] = 8'h00;
    mem_w[254] = 8'h01; mem_w[255] = 8'h09; mem_w[0] = 8'h04;
    load(8'h00, 8'h05, 8'h03, 8'h13, 8'h07);
    tick(); tick();
    check("rst_pc", pc, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", issue_valid, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_cnt", cnt, 16'h0);
    check("rst_ren", mem_ren, 1'b0);
    check("rst_pc_w", pc_w, 8'hFE);
    rst_n = 1'b1;

    // ADD then HALT, ready always high
    pulse_start();
    wait_valid(1, n);
    check("add_lat", n, 7);
    check("add_instr", instr, 8'h00);
    check("add_a", opa, 8'h05);
    check("add_b", opb, 8'h03);
    check("add_pc", pc, 8'h03);
    tick();
    wait_valid(1, n);
    check("halt_lat", n, 5);
    check("halt_instr", instr, 8'h13);
    check("halt_a", opa, 8'h07);
    check("halt_b", opb, 8'h00);
    tick();
    check("p1_halted", halted, 1'b1);
    check("p1_busy", busy, 1'b0);
    check("p1_valid", issue_valid, 1'b0);
    check("p1_pc", pc, 8'h05);
    check("p1_cnt", cnt, 16'd2);
    pulse_start();
    ren = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mem_ren) ren++;
    end
    check("p1_no_ren", ren, 0);
    check("p1_pc_frozen", pc, 8'h05);
    check("p1_cnt_frozen", cnt, 16'd2);
    check("p1_still_halted", halted, 1'b1);

    // Back-pressure: ready low for three ISSUE cycles
    do_reset();
    ready = 1'b0;
    pulse_start();
    wait_valid(1, n);
    check("bp_lat", n, 7);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_valid", issue_valid, 1'b1);
      check("bp_instr", instr, 8'h00);
      check("bp_a", opa, 8'h05);
      check("bp_b", opb, 8'h03);
      check("bp_pc", pc, 8'h03);
      check("bp_cnt", cnt, 16'd0);
    end
    ready = 1'b1;
    tick();
    check("bp_cnt_after", cnt, 16'd1);
    check("bp_valid_after", issue_valid, 1'b0);

    // NOP, NOT, HALT
    do_reset();
    load(8'hFF, 8'h14, 8'hAA, 8'h13, 8'h00);
    pulse_start();
    wait_valid(1, n);
    check("nop_lat", n, 3);
    check("nop_instr", instr, 8'hFF);
    check("nop_a", opa, 8'h00);
    check("nop_b", opb, 8'h00);
    tick();
    wait_valid(1, n);
    check("not_lat", n, 5);
    check("not_instr", instr, 8'h14);
    check("not_a", opa, 8'hAA);
    check("not_b", opb, 8'h00);
    tick();
    wait_valid(1, n);
    check("h3_lat", n, 5);
    check("h3_instr", instr, 8'h13);
    tick();
    check("p3_cnt", cnt, 16'd3);
    check("p3_halted", halted, 1'b1);
    check("p3_pc", pc, 8'h05);

    // Reset out of HALTED, then reset mid-instruction (C_A)
    rst_n = 1'b0;
    tick();
    check("hrst_cnt", cnt, 16'd0);
    check("hrst_halted", halted, 1'b0);
    check("hrst_pc", pc, 8'h00);
    rst_n = 1'b1;
    load(8'h0A, 8'h11, 8'h22, 8'h13, 8'h00);
    pulse_start();
    tick(); tick(); tick();
    check("ca_pc", pc, 8'h02);
    check("ca_instr", instr, 8'h0A);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mrst_busy", busy, 1'b0);
    check("mrst_valid", issue_valid, 1'b0);
    check("mrst_instr", instr, 8'h00);
    check("mrst_a", opa, 8'h00);
    check("mrst_b", opb, 8'h00);
    check("mrst_pc", pc, 8'h00);
    check("mrst_ren", mem_ren, 1'b0);
    // start held across a busy cycle must not disturb the fetch
    start = 1'b1;
    tick(); tick();
    start = 1'b0;
    wait_valid(2, n);
    check("re_lat", n, 7);
    check("re_instr", instr, 8'h0A);
    check("re_a", opa, 8'h11);
    check("re_b", opb, 8'h22);
    check("re_pc", pc, 8'h03);
    tick();
    wait_valid(1, n);
    check("re_halt_lat", n, 5);
    tick();
    check("re_halted", halted, 1'b1);
    check("re_cnt", cnt, 16'd2);

    // End-of-memory wrap on the START_ADDR=254 instance
    start_w = 1'b1;
    tick();
    start_w = 1'b0;
    wait_valid_w(n);
    check("w_lat", n, 7);
    check("w_instr", instr_w, 8'h01);
    check("w_a", opa_w, 8'h09);
    check("w_b", opb_w, 8'h04);
    check("w_pc", pc_w, 8'h01);
    tick();
    check("w_halted", halted_w, 1'b1);
    check("w_busy", busy_w, 1'b0);
    check("w_pc_end", pc_w, 8'h01);
    check("w_cnt", cnt_w, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_issue.md
Name: instr_fetch_issue

Overview:
- Hardware front end for the Processador datapath: walks a byte-wide program memory, decodes each opcode's operand count, and gathers 0/1/2 operand bytes.
- Presents {opcode, operand_a, operand_b} to the execute stage over a valid/ready handshake; the execute stage loads operand_a into regs[0] and operand_b into regs[1].
- Stops on HALT or at end of memory.

Parameters:
AW, 8, program-memory address width (depth 2**AW bytes)
START_ADDR, 0, first opcode address after start

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  begin fetching; sampled only in IDLE
mem_ren  out  1  program-memory read strobe
mem_addr  out  AW  read address (= pc)
mem_rdata  in  8  read data, valid exactly 1 cycle after mem_ren
issue_valid  out  1  instruction bundle valid
issue_ready  in  1  execute stage accepts bundle
instr  out  8  opcode
operand_a  out  8  first operand (0 when none)
operand_b  out  8  second operand (0 when none)
busy  out  1  high in every state except IDLE and HALTED
halted  out  1  high in HALTED
pc  out  AW  next read address
issue_count  out  16  issued bundles, saturates at 16'hFFFF

Behaviour:
- Reset:
  - rst_n low at a clk edge -> IDLE.
  - pc=START_ADDR; all other outputs 0; mem_end flag cleared.
  - Any in-flight read is discarded.
  - Reset has priority over every other event, including mid-instruction and HALTED.
- Operand count, by opcode:
  - 0x00..0x0B (ADD, SUB, MUL, DIV, MOD, AND, OR, XOR, >, <, ==, !=) -> 2 operands.
  - 0x0C..0x14 (MOV, SHL, SHR, BCLR_LSB, BCLR_MSB, IN, OUT, HALT, NOT) -> 1 operand.
  - All others (NOP/invalid) -> 0 operands.
- FSM states: IDLE, F_OPC, D_OPC, F_A, C_A, F_B, C_B, ISSUE, HALTED.
- IDLE:
  - start=1 -> F_OPC.
  - start is ignored in every other state.
- Fetch states (F_*):
  - mem_ren=1 and mem_addr=pc for one cycle.
  - pc <= pc+1 modulo 2**AW.
  - A read at address 2**AW-1 sets sticky mem_end.
- D_OPC:
  - instr <= mem_rdata; operand_a, operand_b <= 0.
  - Next state by operand count: 2 or 1 -> F_A; 0 -> ISSUE.
- C_A: operand_a <= mem_rdata; next F_B if 2 operands, else ISSUE.
- C_B: operand_b <= mem_rdata; next ISSUE.
- ISSUE:
  - issue_valid=1.
  - instr, operand_a and operand_b are held stable until issue_ready=1.
  - On handshake:
    - issue_count += 1, saturating.
    - Next state: HALTED if instr==0x13 or mem_end=1; otherwise F_OPC.
- mem_ren is 0 in D_OPC, C_A, C_B, ISSUE, IDLE and HALTED.
- Latency, counted from the start edge (or from the previous handshake edge): issue_valid first high in
  - cycle 7 for a 2-operand instruction,
  - cycle 5 for a 1-operand instruction,
  - cycle 3 for a 0-operand instruction.
- End-of-memory boundary: operand reads crossing address 2**AW-1 wrap to 0 and the instruction completes normally. No opcode is fetched after mem_end is set.
- HALTED: terminal; exit only via reset. issue_valid=0; pc frozen.
- issue_ready is ignored outside ISSUE.

Test Plan:
- Memory {00,05,03,13,07}; start; issue_ready=1 -> first bundle instr=00, a=05, b=03 in cycle 7; second bundle instr=13, a=07, b=00; then halted=1, busy=0, pc=5, issue_count=2, no further mem_ren.
- Same program with issue_ready=0 for 3 cycles during the first ISSUE -> issue_valid, instr, a and b held constant; pc stays 3; handshake on the 4th cycle; issue_count=1.
- Memory {FF,14,AA,13,00}, ready=1 -> NOP bundle (FF,00,00) in cycle 3 after start; NOT bundle (14,AA,00) 5 cycles after the NOP handshake; then HALT bundle; issue_count=3.
- AW=8, START_ADDR=254, mem[254]=01, mem[255]=09, mem[0]=04 -> bundle (01,09,04); mem_end=1; halted=1 after handshake; pc=1.
- rst_n low during C_A of an ADD -> next cycle state IDLE, all outputs 0, pc=START_ADDR; a subsequent start refetches from START_ADDR.
- start pulsed while busy or halted -> no effect on pc, state or issue_count.
